// File: rtl/serial_divider_pkg.sv
// Shared types and defaults for the multi-cycle restoring divider.
package serial_divider_pkg;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/serial_divider_if.sv
// Pipeline-to-divider request/result bundle; master is the pipeline side.
interface serial_divider_if #(parameter int WIDTH = serial_divider_pkg::DEFAULT_WIDTH);
    logic             en;
    logic             sign;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             devwait;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (output en, sign, opA, opB, input devwait, quotient, remainder);
    modport slave  (input en, sign, opA, opB, output devwait, quotient, remainder);
endinterface

// File: rtl/serial_divider_div_step.sv
// One restoring division step on magnitudes; quotient register shifts the dividend out MSB-first.
module div_step #(
    parameter int WIDTH = serial_divider_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Remainder stays below the divisor, so WIDTH+1 bits hold the trial difference and its sign.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign o_rem   = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

// File: rtl/serial_divider.sv
// Multi-cycle signed/unsigned divider: one quotient bit per cycle, sign fix-up at the end.
module serial_divider
    import serial_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    serial_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_a_neg = bus.sign & bus.opA[WIDTH-1];
    assign w_b_neg = bus.sign & bus.opB[WIDTH-1];
    assign w_abs_a = w_a_neg ? -bus.opA : bus.opA;
    assign w_abs_b = w_b_neg ? -bus.opB : bus.opB;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        if (bus.opB != '0) begin
                            r_quo   <= w_abs_a;
                            r_div   <= w_abs_b;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= CW'(WIDTH);
                            r_state <= S_BUSY;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= bus.opA;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    // Pipeline dropping en means the instruction was squashed.
                    if (!bus.en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (!bus.en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_quotient  <= r_neg_q ? -r_quo : r_quo;
                        r_remainder <= r_neg_r ? -r_rem : r_rem;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.devwait   = ((r_state == S_IDLE) && bus.en) ||
                           (r_state == S_BUSY) || (r_state == S_FIXUP);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
endmodule
